// File: rtl/sprite_blitter.sv
// sprite_blitter: scans a sprite ROM and plots clipped, optionally transparent pixels.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module sprite_blitter #(
  parameter int SPR_W       = 80,
  parameter int SPR_H       = 120,
  parameter int SCR_W       = 160,
  parameter int SCR_H       = 120,
  parameter int XW          = 8,
  parameter int YW          = 7,
  parameter int AW          = 15,
  parameter int CW          = 3,
  parameter int ROM_LAT     = 1,
  parameter int TRANSPARENT = 0
) (
  input  logic          CLOCK_50,
  input  logic          reset_n,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [1:0]    img_sel,
  input  logic [CW-1:0] fg_colour,
  input  logic [CW-1:0] bg_colour,
  output logic [AW-1:0] rom_addr,
  output logic [1:0]    rom_sel,
  input  logic          rom_q,
  output logic [XW-1:0] vga_x,
  output logic [YW-1:0] vga_y,
  output logic [CW-1:0] vga_colour,
  output logic          vga_plot,
  output logic          busy,
  output logic          done
);

  localparam int CLW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RWW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam logic [CLW-1:0] COL_LAST   = CLW'(SPR_W - 1);
  localparam logic [RWW-1:0] ROW_LAST   = RWW'(SPR_H - 1);
  localparam logic [XW:0]    X_LIM      = (XW + 1)'(SCR_W);
  localparam logic [YW:0]    Y_LIM      = (YW + 1)'(SCR_H);
  localparam logic [2:0]     DRAIN_LAST = 3'(ROM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [CLW-1:0] col;
  logic [RWW-1:0] row;
  logic [AW-1:0]  addr;
  logic [2:0]     drain_cnt;

  logic [XW-1:0] x_lat;
  logic [YW-1:0] y_lat;
  logic [1:0]    sel_lat;
  logic [CW-1:0] fg_lat;
  logic [CW-1:0] bg_lat;

  logic accept;
  logic scan_last;
  logic drain_last;

  assign accept     = (state == IDLE) && start;
  assign scan_last  = (state == SCAN) && (col == COL_LAST) && (row == ROW_LAST);
  assign drain_last = (state == DRAIN) && (drain_cnt == DRAIN_LAST);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SCAN;
      SCAN:    if (scan_last) state_nx = DRAIN;
      DRAIN:   if (drain_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Running address counter stands in for row*SPR_W+col; it holds on the last pixel.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      col       <= '0;
      row       <= '0;
      addr      <= '0;
      drain_cnt <= '0;
      x_lat     <= '0;
      y_lat     <= '0;
      sel_lat   <= '0;
      fg_lat    <= '0;
      bg_lat    <= '0;
    end else begin
      if (accept) begin
        x_lat   <= x0;
        y_lat   <= y0;
        sel_lat <= img_sel;
        fg_lat  <= fg_colour;
        bg_lat  <= bg_colour;
        col     <= '0;
        row     <= '0;
        addr    <= '0;
      end else if ((state == SCAN) && !scan_last) begin
        addr <= addr + AW'(1);
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + RWW'(1);
        end else begin
          col <= col + CLW'(1);
        end
      end
      if (state == DRAIN) drain_cnt <= drain_cnt + 3'd1;
      else                drain_cnt <= '0;
    end
  end

  // Coordinates are summed one bit wider so off-screen pixels clip instead of wrapping.
  logic [XW:0] sum_x;
  logic [YW:0] sum_y;

  assign sum_x = {1'b0, x_lat} + (XW + 1)'(col);
  assign sum_y = {1'b0, y_lat} + (YW + 1)'(row);

  logic [ROM_LAT-1:0][XW:0] px;
  logic [ROM_LAT-1:0][YW:0] py;
  logic [ROM_LAT-1:0]       pv;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      px <= '0;
      py <= '0;
      pv <= '0;
    end else begin
      px[0] <= sum_x;
      py[0] <= sum_y;
      pv[0] <= (state == SCAN);
      for (int i = 1; i < ROM_LAT; i++) begin
        px[i] <= px[i-1];
        py[i] <= py[i-1];
        pv[i] <= pv[i-1];
      end
    end
  end

  logic on_screen;
  logic see_through;

  assign on_screen   = (px[ROM_LAT-1] < X_LIM) && (py[ROM_LAT-1] < Y_LIM);
  assign see_through = (TRANSPARENT == 1) && rom_q;

  assign rom_addr   = addr;
  assign rom_sel    = sel_lat;
  assign vga_x      = px[ROM_LAT-1][XW-1:0];
  assign vga_y      = py[ROM_LAT-1][YW-1:0];
  assign vga_colour = rom_q ? bg_lat : fg_lat;
  assign vga_plot   = pv[ROM_LAT-1] && on_screen && !see_through;
  assign busy       = (state == SCAN) || (state == DRAIN);
  assign done       = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: three parameterisations checked cycle-by-cycle against a pixel-level model.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_sprite_blitter;

  localparam int XW = 8, YW = 7, AW = 15, CW = 3;
  localparam int SW = 4, SH = 2, NPIX = 8, LAST_CYC = 13;

  logic          CLOCK_50 = 1'b0;
  logic          reset_n  = 1'b0;
  logic          start    = 1'b0;
  logic [XW-1:0] x0       = '0;
  logic [YW-1:0] y0       = '0;
  logic [1:0]    img_sel  = '0;
  logic [CW-1:0] fg_colour = '0;
  logic [CW-1:0] bg_colour = '0;

  wire [2:0][AW-1:0] rom_addr_w;
  wire [2:0][1:0]    rom_sel_w;
  wire [2:0][XW-1:0] vga_x_w;
  wire [2:0][YW-1:0] vga_y_w;
  wire [2:0][CW-1:0] vga_colour_w;
  wire [2:0]         plot_w;
  wire [2:0]         busy_w;
  wire [2:0]         done_w;

  logic rom_mem [4][8];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cnt [3];

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic int lat_of(input int id);
    return (id == 2) ? 3 : 1;
  endfunction

  function automatic int tr_of(input int id);
    return (id == 1) ? 1 : 0;
  endfunction

  // dut0: latency 1 opaque, dut1: latency 1 transparent, dut2: latency 3 opaque
  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      logic [3:0] q_pipe = '0;
      logic       q;
      sprite_blitter #(
        .SPR_W(SW), .SPR_H(SH), .SCR_W(160), .SCR_H(120),
        .XW(XW), .YW(YW), .AW(AW), .CW(CW),
        .ROM_LAT(lat_of(g)), .TRANSPARENT(tr_of(g))
      ) u_dut (
        .CLOCK_50  (CLOCK_50),
        .reset_n   (reset_n),
        .start     (start),
        .x0        (x0),
        .y0        (y0),
        .img_sel   (img_sel),
        .fg_colour (fg_colour),
        .bg_colour (bg_colour),
        .rom_addr  (rom_addr_w[g]),
        .rom_sel   (rom_sel_w[g]),
        .rom_q     (q),
        .vga_x     (vga_x_w[g]),
        .vga_y     (vga_y_w[g]),
        .vga_colour(vga_colour_w[g]),
        .vga_plot  (plot_w[g]),
        .busy      (busy_w[g]),
        .done      (done_w[g])
      );
      always @(posedge CLOCK_50)
        q_pipe <= {q_pipe[2:0], rom_mem[rom_sel_w[g]][rom_addr_w[g][2:0]]};
      assign q = q_pipe[lat_of(g)-1];
    end
  endgenerate

  task automatic chk(input string nm, input int id, input int c, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", nm, id, c, act, exp);
    end
  endtask

  // Expected behaviour of cycle c (1 = first cycle after the start edge), from pixel arithmetic.
  task automatic check_cycle(input int c, input int id, input int x, input int y,
                             input int sel, input int fg, input int bg);
    int lat, k, xs, ys, b, ep, eb, ed;
    lat = lat_of(id);
    eb  = (c >= 1 && c <= NPIX + lat) ? 1 : 0;
    ed  = (c == NPIX + lat + 1) ? 1 : 0;
    k   = c - lat - 1;
    ep = 0; b = 0; xs = 0; ys = 0;
    if (k >= 0 && k < NPIX) begin
      xs = x + k % SW;
      ys = y + k / SW;
      b  = rom_mem[sel][k] ? 1 : 0;
      ep = (xs < 160 && ys < 120 && !(tr_of(id) == 1 && b == 1)) ? 1 : 0;
    end
    chk("busy", id, c, busy_w[id], eb);
    chk("done", id, c, done_w[id], ed);
    chk("vga_plot", id, c, plot_w[id], ep);
    if (c >= 1 && c <= NPIX) begin
      chk("rom_addr", id, c, rom_addr_w[id], c - 1);
      chk("rom_sel", id, c, rom_sel_w[id], sel);
    end
    if (ep == 1) begin
      chk("vga_x", id, c, vga_x_w[id], xs);
      chk("vga_y", id, c, vga_y_w[id], ys);
      chk("vga_colour", id, c, vga_colour_w[id], (b == 1) ? bg : fg);
    end
    if (plot_w[id]) cnt[id]++;
  endtask

  // Inputs are scrambled after the start edge to prove the blit uses latched values.
  task automatic run_blit(input int x, input int y, input int sel, input int fg, input int bg);
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    x0 = XW'(x); y0 = YW'(y); img_sel = 2'(sel); fg_colour = CW'(fg); bg_colour = CW'(bg);
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    x0 = XW'($urandom); y0 = YW'($urandom); img_sel = 2'($urandom);
    fg_colour = CW'($urandom); bg_colour = CW'($urandom);
    for (int c = 1; c <= LAST_CYC; c++) begin
      for (int id = 0; id < 3; id++) check_cycle(c, id, x, y, sel, fg, bg);
      @(posedge CLOCK_50); #1;
    end
  endtask

  typedef struct {
    int x; int y; int sel; int fg; int bg;
    int n_opaque; int n_transp;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{10,  5,   0, 3, 6, 8, 8};
    tbl[1] = '{158, 5,   0, 5, 2, 4, 4};
    tbl[2] = '{10,  5,   1, 4, 1, 8, 4};
    tbl[3] = '{20,  119, 1, 7, 2, 4, 2};
    tbl[4] = '{255, 127, 0, 1, 6, 0, 0};
    tbl[5] = '{158, 119, 1, 2, 5, 2, 1};

    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 8; a++)
        rom_mem[s][a] = (s == 0) ? 1'b0 : (s == 1) ? ((a % 2) == 0) : 1'($urandom);

    reset_n = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    for (int id = 0; id < 3; id++) begin
      chk("rst_busy", id, 0, busy_w[id], 0);
      chk("rst_done", id, 0, done_w[id], 0);
      chk("rst_plot", id, 0, plot_w[id], 0);
      chk("rst_addr", id, 0, rom_addr_w[id], 0);
      chk("rst_sel", id, 0, rom_sel_w[id], 0);
      chk("rst_x", id, 0, vga_x_w[id], 0);
      chk("rst_y", id, 0, vga_y_w[id], 0);
      chk("rst_colour", id, 0, vga_colour_w[id], 0);
    end
    reset_n = 1'b1;
    @(posedge CLOCK_50); #1;

    for (int i = 0; i < 6; i++) begin
      run_blit(tbl[i].x, tbl[i].y, tbl[i].sel, tbl[i].fg, tbl[i].bg);
      chk("plots_opaque", 0, i, cnt[0], tbl[i].n_opaque);
      chk("plots_transp", 1, i, cnt[1], tbl[i].n_transp);
      chk("plots_lat3", 2, i, cnt[2], tbl[i].n_opaque);
    end

    for (int r = 0; r < 8; r++)
      run_blit($urandom_range(140, 255), $urandom_range(0, 127), $urandom_range(0, 3),
               $urandom_range(0, 7), $urandom_range(0, 7));

    // start held high: each instance restarts one idle cycle after done
    x0 = 8'd30; y0 = 7'd40; img_sel = 2'd2; fg_colour = 3'd5; bg_colour = 3'd2;
    start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(posedge CLOCK_50); #1;
      if (c == 10) chk("held_done", 0, c, done_w[0], 1);
      if (c == 11) chk("held_idle", 0, c, busy_w[0], 0);
      if (c == 12) begin
        chk("held_restart", 0, c, busy_w[0], 1);
        chk("held_addr", 0, c, rom_addr_w[0], 0);
      end
      if (c == 13) chk("held_idle", 2, c, busy_w[2], 0);
      if (c == 14) begin
        chk("held_restart", 2, c, busy_w[2], 1);
        chk("held_addr", 2, c, rom_addr_w[2], 0);
      end
    end
    start = 1'b0;
    reset_n = 1'b0;
    @(posedge CLOCK_50); #1;
    reset_n = 1'b1;
    @(posedge CLOCK_50); #1;

    // mid-blit start pulse is ignored, then an asynchronous reset aborts the blit
    x0 = 8'd10; y0 = 7'd5; img_sel = 2'd1; fg_colour = 3'd6; bg_colour = 3'd1;
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      for (int id = 0; id < 3; id++) check_cycle(c, id, 10, 5, 1, 6, 1);
      if (c == 3) begin
        start = 1'b1;
        x0 = 8'd100;
      end else begin
        start = 1'b0;
      end
      @(posedge CLOCK_50); #1;
    end
    reset_n = 1'b0;
    #1;
    for (int id = 0; id < 3; id++) begin
      chk("abort_busy", id, 5, busy_w[id], 0);
      chk("abort_plot", id, 5, plot_w[id], 0);
      chk("abort_addr", id, 5, rom_addr_w[id], 0);
      chk("abort_colour", id, 5, vga_colour_w[id], 0);
    end
    repeat (2) @(posedge CLOCK_50);
    #1;
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLOCK_50); #1;
      for (int id = 0; id < 3; id++) begin
        chk("post_rst_plot", id, c, plot_w[id], 0);
        chk("post_rst_busy", id, c, busy_w[id], 0);
      end
    end
    run_blit(10, 5, 1, 6, 1);
    chk("plots_after_rst", 0, 0, cnt[0], 8);
    chk("plots_after_rst", 1, 0, cnt[1], 4);
    chk("plots_after_rst", 2, 0, cnt[2], 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- SPR_W, 80: sprite width in pixels.
- SPR_H, 120: sprite height in pixels.
- SCR_W, 160: screen width.
- SCR_H, 120: screen height.
- XW, 8: x coordinate width.
- YW, 7: y coordinate width.
- AW, 15: ROM address width.
- CW, 3: colour width.
- ROM_LAT, 1: ROM read latency in cycles (1..4).
- TRANSPARENT, 0: when 1, background pixels are not plotted.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLOCK_50, in, 1: clock.
- reset_n, in, 1: reset, asynchronous, active-low.
- start, in, 1: request a blit.
- x0, in, XW: sprite origin x.
- y0, in, YW: sprite origin y.
- img_sel, in, 2: image select.
- fg_colour, in, CW: foreground colour.
- bg_colour, in, CW: background colour.
- rom_addr, out, AW: sprite-local ROM address.
- rom_sel, out, 2: latched image select.
- rom_q, in, 1: ROM data.
- vga_x, out, XW: plot x.
- vga_y, out, YW: plot y.
- vga_colour, out, CW: plot colour.
- vga_plot, out, 1: plot strobe.
- busy, out, 1: blit in progress.
- done, out, 1: one-cycle completion pulse.

Function
REQ-003 The FSM SHALL have four states: IDLE, SCAN, DRAIN, DONE.
REQ-004 In IDLE, start=1 SHALL latch x0, y0, img_sel, fg_colour and bg_colour, clear col, row and addr, and enter SCAN.
REQ-005 start SHALL be ignored in SCAN, DRAIN and DONE; the latched values SHALL NOT change during a blit.
REQ-006 In SCAN, each cycle SHALL present rom_addr=addr, then addr+1 and col+1; at col=SPR_W-1, col SHALL wrap to 0 and row SHALL increment.
REQ-007 rom_addr SHALL equal row*SPR_W+col, produced by a running counter with no multiplier.
REQ-008 After the cycle with col=SPR_W-1 and row=SPR_H-1, the FSM SHALL enter DRAIN for exactly ROM_LAT cycles, then DONE for 1 cycle, then IDLE.
REQ-009 Screen coordinates (x0+col, y0+row) and a valid bit SHALL be delayed ROM_LAT stages, so they align with rom_q for the same address.
REQ-010 vga_plot SHALL be 1 only when all of the following hold: the delayed valid bit is 1; the sum x0+col, computed at XW+1 bits, is < SCR_W; the sum y0+row, computed at YW+1 bits, is < SCR_H; and NOT (TRANSPARENT=1 and rom_q=1).
REQ-011 Clipped pixels SHALL still consume their scan cycle; no wrap-around onto the screen SHALL occur.
REQ-012 vga_colour SHALL be bg_colour when rom_q=1 and fg_colour when rom_q=0; vga_x and vga_y SHALL be the delayed coordinates truncated to XW and YW bits.
REQ-013 rom_sel SHALL drive the latched img_sel throughout SCAN and DRAIN.
REQ-014 busy SHALL be 1 in SCAN and DRAIN and 0 otherwise; done SHALL be 1 only in DONE.
REQ-015 Timing SHALL be: start sampled at edge 0; addr 0 presented in cycle 1; first possible plot in cycle 1+ROM_LAT; done in cycle SPR_W*SPR_H+ROM_LAT+1.
REQ-016 start held high continuously SHALL start a new blit on the cycle after DONE, i.e. in IDLE.

Reset
REQ-017 reset_n=0 SHALL asynchronously force the following, including mid-blit:
- state IDLE;
- col, row, addr and the pipeline valid bits cleared;
- rom_addr=0, rom_sel=0, vga_x=0, vga_y=0, vga_colour=0;
- vga_plot=0, busy=0, done=0.
REQ-018 After reset release, no plot SHALL occur until a new start is accepted.

Verification
REQ-019 SPR_W=4, SPR_H=2, ROM_LAT=1; start with x0=10, y0=5, rom_q=0 -> exactly 8 plots with fg_colour at (10..13,5) then (10..13,6); done in cycle 10.
REQ-020 Same configuration, x0=158 -> plots only at x=158 and x=159 on each row (4 plots); done cycle unchanged; no plot at x=0 or x=1.
REQ-021 TRANSPARENT=1, ROM pattern 1,0,1,0,... -> 4 plots, all fg_colour, at odd col; with TRANSPARENT=0 -> 8 plots, alternating bg and fg.
REQ-022 ROM_LAT=3 -> rom_addr sequence 0..7 in cycles 1..8; plots in cycles 4..11; done in cycle 12; colours match the ROM model.
REQ-023 Pulse start at cycle 3 mid-blit with changed x0 -> no effect; then assert reset_n=0 at cycle 5 -> busy=0 and vga_plot=0 immediately; next start -> blit from addr 0.
